// File: rtl/i_cache_refill.sv
// Instruction-cache miss handler: dedups per-slot misses into a line-address queue and refills lines from memory.
// Latency: miss in cycle N -> request N+2, beats from N+3, refill write pulse one cycle after the last beat.
// Backpressure: mem_req_ready stalls the request; refill_stall rises when fewer than 2 queue entries are free; excess misses are dropped.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   miss[2], miss_addr[2]          per-slot miss indication and PC (slot 0 has priority)
//   ext_flush                      clears the pending queue; an in-flight line still completes
//   refill_stall                   fewer than 2 free queue entries
//   mem_req_valid/ready/addr       line request handshake, line-aligned address
//   mem_resp_valid/data            32-bit response beats, word 0 first
//   fetch_addr/_valid, fetched_data   one-cycle refill write of an assembled line
//
// Optional feature macro: ICACHE_NEXT_LINE_PREFETCH_EN (next-line prefetch after a demand refill).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module i_cache_refill #(
    parameter int LINE_SIZE   = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                miss,
    input  logic [`ADDR_WIDTH-1:0]    miss_addr [2],
    input  logic                      ext_flush,
    output logic                      refill_stall,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [`ADDR_WIDTH-1:0]    mem_req_addr,
    input  logic                      mem_resp_valid,
    input  logic [31:0]               mem_resp_data,
    output logic [`ADDR_WIDTH-1:0]    fetch_addr,
    output logic                      fetch_addr_valid,
    output logic [32*LINE_SIZE-1:0]   fetched_data
);

    localparam int AW  = `ADDR_WIDTH;
    localparam int OFF = 2 + $clog2(LINE_SIZE);
    localparam int BW  = $clog2(LINE_SIZE);
    localparam int PW  = $clog2(QUEUE_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [AW-1:0] BASE_MASK = ~((AW'(1) << OFF) - AW'(1));

    typedef enum logic [1:0] {IDLE, REQ, BEATS, WRITE} state_t;

    state_t state_q, state_d;

    // Pending-miss queue: circular buffer of line bases.
    logic [AW-1:0]          q_addr [QUEUE_DEPTH];
    logic [PW-1:0]          head_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          free_cnt;
    logic [QUEUE_DEPTH-1:0] q_vld;
    logic [PW-1:0]          tail0, tail1;

    logic [AW-1:0] base0, base1;
    logic          hit0, hit1;
    logic          push0, push1, pop;

    logic [AW-1:0]                cur_addr_q;
    logic [BW-1:0]                beat_q;
    logic                         last_beat;
    logic [LINE_SIZE-1:0][31:0]   line_q, line_nxt;
    logic [AW-1:0]                fetch_addr_q;
    logic [LINE_SIZE-1:0][31:0]   fetched_data_q;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    logic is_pf_q;
    logic pf_go;
    // Only a demand line may spawn a prefetch, and only when nothing is waiting.
    assign pf_go = !is_pf_q && (count_q == '0) && !ext_flush;
`endif

    assign base0    = miss_addr[0] & BASE_MASK;
    assign base1    = miss_addr[1] & BASE_MASK;
    assign free_cnt = CW'(QUEUE_DEPTH) - count_q;
    assign refill_stall = free_cnt < CW'(2);

    // An entry is live when its distance from head is below the count.
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            q_vld[i] = {1'b0, PW'(i) - head_q} < count_q;
        end
    end

    // Duplicate detection against live queue entries and the in-flight line.
    always_comb begin
        hit0 = (state_q != IDLE) && (cur_addr_q == base0);
        hit1 = (state_q != IDLE) && (cur_addr_q == base1);
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (q_vld[i] && (q_addr[i] == base0)) hit0 = 1'b1;
            if (q_vld[i] && (q_addr[i] == base1)) hit1 = 1'b1;
        end
    end

    // Free space comes from the registered count; a same-cycle pop does not make room.
    assign push0 = miss[0] && !hit0 && !ext_flush && (free_cnt != '0);
    assign push1 = miss[1] && !hit1 && !(miss[0] && (base1 == base0)) && !ext_flush
                   && (free_cnt > CW'(push0));
    assign pop   = (state_q == IDLE) && (count_q != '0) && !ext_flush;
    assign tail0 = head_q + count_q[PW-1:0];
    assign tail1 = tail0 + PW'(push0);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            count_q <= '0;
        end else if (ext_flush) begin
            head_q  <= '0;
            count_q <= '0;
        end else begin
            if (push0) q_addr[tail0] <= base0;
            if (push1) q_addr[tail1] <= base1;
            if (pop)   head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    assign last_beat = (beat_q == BW'(LINE_SIZE - 1));

    always_comb begin
        line_nxt         = line_q;
        line_nxt[beat_q] = mem_resp_data;
    end

    // FSM: next state and handshake outputs.
    always_comb begin
        state_d          = state_q;
        mem_req_valid    = 1'b0;
        fetch_addr_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) state_d = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = BEATS;
            end
            BEATS: begin
                if (mem_resp_valid && last_beat) state_d = WRITE;
            end
            WRITE: begin
                fetch_addr_valid = 1'b1;
                state_d          = IDLE;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
                if (pf_go) state_d = REQ;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath: current line address, beat assembly, held refill outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr_q     <= '0;
            beat_q         <= '0;
            line_q         <= '0;
            fetch_addr_q   <= '0;
            fetched_data_q <= '0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
            is_pf_q        <= 1'b0;
`endif
        end else begin
            if (pop) begin
                cur_addr_q <= q_addr[head_q];
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
                is_pf_q    <= 1'b0;
`endif
            end
            if ((state_q == REQ) && mem_req_ready) beat_q <= '0;
            if ((state_q == BEATS) && mem_resp_valid) begin
                line_q <= line_nxt;
                beat_q <= beat_q + BW'(1);
                if (last_beat) begin
                    fetch_addr_q   <= cur_addr_q;
                    fetched_data_q <= line_nxt;
                end
            end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
            if ((state_q == WRITE) && pf_go) begin
                cur_addr_q <= cur_addr_q + AW'(4 * LINE_SIZE);
                is_pf_q    <= 1'b1;
            end
`endif
        end
    end

    assign mem_req_addr = cur_addr_q;
    assign fetch_addr   = fetch_addr_q;
    assign fetched_data = fetched_data_q;

endmodule

// File: tb/tb_i_cache_refill.sv
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_i_cache_refill;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [1:0]             miss;
    logic [`ADDR_WIDTH-1:0] miss_addr [2];
    logic                   ext_flush;
    logic                   refill_stall;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [`ADDR_WIDTH-1:0] mem_req_addr;
    logic                   mem_resp_valid;
    logic [31:0]            mem_resp_data;
    logic [`ADDR_WIDTH-1:0] fetch_addr;
    logic                   fetch_addr_valid;
    logic [63:0]            fetched_data;

    i_cache_refill #(.LINE_SIZE(2), .QUEUE_DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .miss             (miss),
        .miss_addr        (miss_addr),
        .ext_flush        (ext_flush),
        .refill_stall     (refill_stall),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .fetch_addr       (fetch_addr),
        .fetch_addr_valid (fetch_addr_valid),
        .fetched_data     (fetched_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } fill_t;

    logic [31:0] req_q [$];
    logic [31:0] beats_q [$];
    fill_t       fill_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    // Memory responder knobs.
    int ready_delay = 0;
    int beat_gap    = 0;
    bit hold_ready  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_line(input logic [31:0] addr, input logic [31:0] w0,
                               input logic [31:0] w1, input logic [63:0] line);
        fill_t f;
        req_q.push_back(addr);
        beats_q.push_back(w0);
        beats_q.push_back(w1);
        f.addr = addr;
        f.data = line;
        fill_q.push_back(f);
    endtask

    task automatic expect_pf(input logic [31:0] addr);
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        expect_line(addr, 32'h5EED0000, 32'h5EED0001, 64'h5EED0001_5EED0000);
`else
        if (addr == 32'hFFFF_FFFF) $display("note: prefetch address sentinel");
`endif
    endtask

    task automatic drive(input logic [1:0] m, input logic [31:0] a0, input logic [31:0] a1);
        @(posedge clk); #1;
        miss         = m;
        miss_addr[0] = a0;
        miss_addr[1] = a1;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while ((req_q.size() != 0 || fill_q.size() != 0) && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        n_checks++;
        if (req_q.size() != 0 || fill_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d reqs and %0d fills pending, expected 0",
                     name, req_q.size(), fill_q.size());
            req_q.delete();
            fill_q.delete();
            beats_q.delete();
        end
        // Quiet window to catch stray requests or refill pulses.
        repeat (20) @(posedge clk);
    endtask

    // Memory responder: grants after ready_delay cycles, then returns two beats with beat_gap idle cycles before each.
    initial begin
        int wait_cnt  = 0;
        int gap_cnt   = 0;
        int beats_left = 0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(posedge clk); #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (reset) begin
                wait_cnt   = 0;
                gap_cnt    = 0;
                beats_left = 0;
            end else if (beats_left > 0) begin
                if (gap_cnt < beat_gap) begin
                    gap_cnt++;
                end else begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = (beats_q.size() != 0) ? beats_q.pop_front() : 32'hDEAD_BEEF;
                    beats_left--;
                    gap_cnt = 0;
                end
            end else if (mem_req_valid && !hold_ready) begin
                if (wait_cnt < ready_delay) begin
                    wait_cnt++;
                end else begin
                    mem_req_ready = 1'b1;
                    wait_cnt      = 0;
                    gap_cnt       = 0;
                    beats_left    = 2;
                end
            end
        end
    end

    // Request monitor: address ordering on handshake, stability while stalled.
    initial begin
        logic        prev_vld  = 1'b0;
        logic        prev_rdy  = 1'b0;
        logic [31:0] prev_addr = '0;
        forever begin
            @(negedge clk);
            if (mem_req_valid && prev_vld && !prev_rdy)
                check("req_addr_stable", mem_req_addr, prev_addr);
            if (mem_req_valid && mem_req_ready) begin
                if (req_q.size() == 0) begin
                    check("req_unexpected", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("req_addr", mem_req_addr, req_q.pop_front());
                end
            end
            prev_vld  = mem_req_valid;
            prev_rdy  = mem_req_ready;
            prev_addr = mem_req_addr;
        end
    end

    // Refill monitor.
    initial begin
        fill_t f;
        forever begin
            @(negedge clk);
            if (fetch_addr_valid) begin
                if (fill_q.size() == 0) begin
                    check("fill_unexpected", fetch_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    f = fill_q.pop_front();
                    check("fill_addr", fetch_addr, f.addr);
                    check("fill_data", fetched_data, f.data);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        miss         = '0;
        miss_addr[0] = '0;
        miss_addr[1] = '0;
        ext_flush    = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_req_addr", mem_req_addr, 0);
        check("rst_fetch_valid", fetch_addr_valid, 0);
        check("rst_fetch_addr", fetch_addr, 0);
        check("rst_fetch_data", fetched_data, 0);
        check("rst_stall", refill_stall, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single miss with cycle-exact latency.
        expect_line(32'h0000_1000, 32'hAAAA0001, 32'hBBBB0002, 64'hBBBB0002_AAAA0001);
        expect_pf(32'h0000_1008);
        drive(2'b01, 32'h0000_1004, 32'h0);
        @(negedge clk); check("t1_req_n0", mem_req_valid, 0);
        drive(2'b00, 32'h0, 32'h0);
        @(negedge clk); check("t1_req_n1", mem_req_valid, 0);
        @(negedge clk); check("t1_req_n2", mem_req_valid, 1);
        check("t1_req_addr_n2", mem_req_addr, 32'h0000_1000);
        @(negedge clk); check("t1_fill_n3", fetch_addr_valid, 0);
        @(negedge clk); check("t1_fill_n4", fetch_addr_valid, 0);
        @(negedge clk); check("t1_fill_n5", fetch_addr_valid, 1);
        drain("single");

        // Dedup: same line on both slots, then again while in flight.
        expect_line(32'h0000_2000, 32'h20000000, 32'h20000001, 64'h20000001_20000000);
        expect_pf(32'h0000_2008);
        drive(2'b11, 32'h0000_2000, 32'h0000_2004);
        drive(2'b00, 32'h0, 32'h0);
        drive(2'b00, 32'h0, 32'h0);
        drive(2'b01, 32'h0000_2000, 32'h0);
        drive(2'b00, 32'h0, 32'h0);
        drain("dedup");

        // Ordering and overflow with the request held off.
        hold_ready = 1'b1;
        expect_line(32'h0000_7000, 32'h70000000, 32'h70000001, 64'h70000001_70000000);
        expect_line(32'h0000_3000, 32'h30000000, 32'h30000001, 64'h30000001_30000000);
        expect_line(32'h0000_4000, 32'h40000000, 32'h40000001, 64'h40000001_40000000);
        expect_line(32'h0000_5000, 32'h50000000, 32'h50000001, 64'h50000001_50000000);
        expect_line(32'h0000_8000, 32'h80000000, 32'h80000001, 64'h80000001_80000000);
        expect_pf(32'h0000_8008);
        drive(2'b01, 32'h0000_7000, 32'h0);
        drive(2'b00, 32'h0, 32'h0);
        drive(2'b00, 32'h0, 32'h0);
        drive(2'b11, 32'h0000_3000, 32'h0000_4000);
        drive(2'b01, 32'h0000_5000, 32'h0);
        @(negedge clk); check("ovf_stall_2", refill_stall, 0);
        drive(2'b11, 32'h0000_8000, 32'h0000_6000);
        @(negedge clk); check("ovf_stall_3", refill_stall, 1);
        drive(2'b00, 32'h0, 32'h0);
        @(negedge clk); check("ovf_stall_4", refill_stall, 1);
        @(posedge clk); #1;
        hold_ready = 1'b0;
        drain("overflow");
        check("ovf_stall_end", refill_stall, 0);

        // Backpressure: slow grant, gapped beats.
        ready_delay = 3;
        beat_gap    = 2;
        expect_line(32'h0000_9010, 32'h9010CAFE, 32'h9014F00D, 64'h9014F00D_9010CAFE);
        expect_pf(32'h0000_9018);
        drive(2'b10, 32'h0, 32'h0000_9014);
        drive(2'b00, 32'h0, 32'h0);
        drain("backpressure");

        // Flush with three queued misses and one line mid-beats.
        ready_delay = 0;
        beat_gap    = 3;
        expect_line(32'h0000_A000, 32'hA0000000, 32'hA0000001, 64'hA0000001_A0000000);
        expect_pf(32'h0000_A008);
        drive(2'b01, 32'h0000_A000, 32'h0);
        drive(2'b00, 32'h0, 32'h0);
        drive(2'b11, 32'h0000_B000, 32'h0000_C000);
        drive(2'b01, 32'h0000_D000, 32'h0);
        drive(2'b01, 32'h0000_E000, 32'h0);
        ext_flush = 1'b1;
        @(negedge clk); check("flush_stall_before", refill_stall, 1);
        drive(2'b00, 32'h0, 32'h0);
        ext_flush = 1'b0;
        @(negedge clk); check("flush_stall_after", refill_stall, 0);
        drain("flush");
        check("flush_stall_end", refill_stall, 0);

        // Reset mid-beats: request issued, no refill pulse afterwards.
        beat_gap = 0;
        req_q.push_back(32'h0000_F000);
        beats_q.push_back(32'hF0000000);
        beats_q.push_back(32'hF0000001);
        drive(2'b01, 32'h0000_F000, 32'h0);
        drive(2'b00, 32'h0, 32'h0);
        drive(2'b00, 32'h0, 32'h0);
        drive(2'b00, 32'h0, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_req_valid", mem_req_valid, 0);
        check("midrst_fetch_valid", fetch_addr_valid, 0);
        check("midrst_stall", refill_stall, 0);
        drain("midreset");
        beats_q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
